// File: rtl/cnn_pkg.sv
// Shared definitions for the basecnn front-end datapath.
//
// Contents:
//   PIX_W_DEF  - default pixel width in bits
//   IMG_W_DEF  - default pixels per row
//   IMG_H_DEF  - default rows per frame
//   state_t    - window generator phase: FILL (rows 0..1), STREAM (rows 2..H-1)
package cnn_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/row_ram.sv
// One image row of pixel storage.
//
// One combinational read and one synchronous write per cycle, both at the
// same address. A read in the write cycle returns the old contents.
//
// Ports:
//   clk    in   rising-edge clock
//   addr   in   AW   shared read/write address (column index)
//   we     in   1    write enable
//   wdata  in   W    data written at the next rising edge
//   rdata  out  W    current contents of mem[addr]
module row_ram #(
  parameter int  DEPTH = 28,
  parameter int  W     = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // NOTE: the storage array has no reset; a reset loop over every entry would
  // prevent mapping onto RAM and nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen.sv
// 3x3 sliding window generator for a raster-order pixel stream.
//
// Two row memories hold the previous two rows (row_a = row r-1,
// row_b = row r-2). Each accepted pixel shifts the 3x3 window left and loads
// a fresh right-hand column {row_b[c], row_a[c], pix_in}. A window is
// presented once the row and column are both at least 2 ("valid"
// convolution, no padding), giving (IMG_W-2)*(IMG_H-2) windows per frame.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   pix_in     in   PIX_W  incoming pixel, raster order
//   pix_valid  in   pix_in is valid
//   pix_ready  out  a pixel can be accepted this cycle
//   win0..win8 out  PIX_W  window, win0 = (r-2,c-2) ... win8 = (r,c)
//   win_valid  out  window outputs hold a valid window
//   win_ready  in   downstream consumes the window this cycle
//   win_last   out  final window of the frame (qualified by win_valid)
module window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] win0,
  output logic [PIX_W-1:0] win1,
  output logic [PIX_W-1:0] win2,
  output logic [PIX_W-1:0] win3,
  output logic [PIX_W-1:0] win4,
  output logic [PIX_W-1:0] win5,
  output logic [PIX_W-1:0] win6,
  output logic [PIX_W-1:0] win7,
  output logic [PIX_W-1:0] win8,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] mid;
  logic             accept;
  logic             produce;
  logic             col_end;
  logic             row_end;
  logic             ram_we;

  // A stalled window blocks intake; there is no skid buffer.
  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col == COL_MAX);
  assign row_end   = (row == ROW_MAX);

  // Columns 0..1 only refill the window, so a window never straddles a
  // row boundary.
  assign produce   = accept && (state == STREAM) && (col >= CW'(2));

  // Pixels presented during reset must not disturb the row memories.
  assign ram_we    = accept && reset;

  // row_a: previous row. Its old value moves down into row_b.
  row_ram #(.DEPTH(IMG_W), .W(PIX_W)) u_row_a (
    .clk   (clk),
    .addr  (col),
    .we    (ram_we),
    .wdata (pix_in),
    .rdata (mid)
  );

  // row_b: two rows back.
  row_ram #(.DEPTH(IMG_W), .W(PIX_W)) u_row_b (
    .clk   (clk),
    .addr  (col),
    .we    (ram_we),
    .wdata (mid),
    .rdata (top)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves it unassigned and a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:   if (accept && col_end && (row == RW'(1))) state_nxt = STREAM;
      STREAM: if (accept && col_end && row_end)         state_nxt = FILL;
      default:                                          state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values; the window shift below depends on it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end

      for (int k = 0; k < 3; k++) begin
        win_q[3*k]     <= win_q[3*k + 1];
        win_q[3*k + 1] <= win_q[3*k + 2];
      end
      win_q[2] <= top;
      win_q[5] <= mid;
      win_q[8] <= pix_in;

      win_valid <= produce;
      win_last  <= produce && col_end && row_end;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on a 5x5 image.
//
// A reference model records every accepted pixel into a 2-D frame array and,
// whenever the pixel completes a 3x3 window, queues that window built by
// plain array indexing. Every consumed DUT window is compared against the
// head of that queue; scenario tasks add directed checks on top.
module tb_window_gen;

  localparam int W = 5;
  localparam int H = 5;
  localparam int P = 8;

  typedef logic [8:0][P-1:0] px_t;

  typedef struct packed {
    px_t  px;
    logic last;
  } win_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [P-1:0] pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [P-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic         win_valid;
  logic         win_ready;
  logic         win_last;

  window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win0      (win0),
    .win1      (win1),
    .win2      (win2),
    .win3      (win3),
    .win4      (win4),
    .win5      (win5),
    .win6      (win6),
    .win7      (win7),
    .win8      (win8),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;

  win_t   exp_q[$];
  win_t   got_q[$];
  int     last_count;
  bit     saw_45;

  logic [P-1:0] frame [H][W];
  int     m_row = 0;
  int     m_col = 0;

  function automatic px_t dut_win();
    return {win8, win7, win6, win5, win4, win3, win2, win1, win0};
  endfunction

  // Expected window whose top-left pixel value is a, for consecutive data.
  function automatic px_t mk(input int a);
    px_t r;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        r[dr*3 + dc] = P'(a + dr*W + dc);
    return r;
  endfunction

  task automatic model_accept(input logic [P-1:0] p);
    win_t w;
    frame[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w.px[dr*3 + dc] = frame[m_row - 2 + dr][m_col - 2 + dc];
      w.last = (m_row == H-1) && (m_col == W-1);
      exp_q.push_back(w);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic tick(output bit acc);
    win_t w;
    @(negedge clk);
    acc = pix_valid && pix_ready;
    if (reset) begin
      if (win_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_window: got win_valid=1 data=%h, required win_valid=0", dut_win());
        end else if (dut_win() !== exp_q[0].px || win_last !== exp_q[0].last) begin
          n_fail++;
          $display("FAIL window_data: got %h last=%b, required %h last=%b",
                   dut_win(), win_last, exp_q[0].px, exp_q[0].last);
        end
        if (win_ready) begin
          w.px   = dut_win();
          w.last = win_last;
          got_q.push_back(w);
          if (win_last) last_count++;
          for (int k = 0; k < 3; k++)
            for (int j = 0; j < 2; j++)
              if (w.px[3*k + j] == P'(4) && w.px[3*k + j + 1] == P'(5)) saw_45 = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL window_latency: got win_valid=0, required 1 for %h", exp_q[0].px);
        void'(exp_q.pop_front());
      end
      if (acc) model_accept(pix_in);
    end else begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    last_count = 0;
    saw_45     = 1'b0;
  endtask

  task automatic do_reset();
    bit acc;
    reset     = 1'b0;
    pix_valid = 1'b1;
    pix_in    = P'($urandom);
    tick(acc);
    tick(acc);
    reset     = 1'b1;
    pix_valid = 1'b0;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 ready, 1 random.
  task automatic send(input int base, input bit rnd, input int vmode,
                      input int rmode, input int npix);
    bit           acc;
    int           sent   = 0;
    int           budget = 0;
    logic [P-1:0] cur;
    cur = rnd ? P'($urandom) : P'(base);
    while (sent < npix && budget < 4000) begin
      pix_in    = cur;
      pix_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
      win_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) begin
        sent++;
        cur = rnd ? P'($urandom) : cur + P'(1);
      end
      budget++;
    end
    pix_valid = 1'b0;
    if (sent < npix) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got %0d pixels accepted, required %0d", sent, npix);
    end
  endtask

  task automatic drain();
    bit acc;
    int budget = 0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    while ((exp_q.size() != 0 || win_valid) && budget < 50) begin
      tick(acc);
      budget++;
    end
    tick(acc);
    if (budget >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d windows pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit acc;
    reset     = 1'b0;
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'hA5;
    tick(acc);
    tick(acc);
    tick(acc);
    n_tests++;
    if ({win_valid, win_last} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b last=%b, required 0 0", win_valid, win_last);
    end
    n_tests++;
    if (dut_win() !== '0) begin
      n_fail++;
      $display("FAIL reset_window: got %h, required 0", dut_win());
    end
    n_tests++;
    if (pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pix_ready: got %b, required 1", pix_ready);
    end
    reset     = 1'b1;
    pix_valid = 1'b0;
    win_ready = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    clear_obs();
    send(0, 1'b0, 0, 0, W*H);
    drain();
    n_tests++;
    if (got_q.size() != (W-2)*(H-2)) begin
      n_fail++;
      $display("FAIL basic_count: got %0d windows, required %0d", got_q.size(), (W-2)*(H-2));
    end else begin
      n_tests++;
      if (got_q[0].px !== mk(0)) begin
        n_fail++;
        $display("FAIL basic_first: got %h, required %h", got_q[0].px, mk(0));
      end
      n_tests++;
      if (got_q[8].px !== mk(12) || got_q[8].last !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_last: got %h last=%b, required %h last=1", got_q[8].px, got_q[8].last, mk(12));
      end
    end
    n_tests++;
    if (last_count != 1 || saw_45) begin
      n_fail++;
      $display("FAIL basic_edges: got last_count=%0d saw_4_5=%b, required 1 0", last_count, saw_45);
    end
  endtask

  task automatic test_back_pressure();
    bit acc;
    do_reset();
    clear_obs();
    send(0, 1'b0, 0, 0, 13);
    n_tests++;
    if (win_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_valid: got %b, required 1", win_valid);
    end
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_in    = P'(13);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      n_tests++;
      if (acc || pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_pix_ready: cycle %0d got %b, required 0", i, pix_ready);
      end
      n_tests++;
      if (win_valid !== 1'b1 || dut_win() !== mk(0)) begin
        n_fail++;
        $display("FAIL bp_stable: cycle %0d got valid=%b %h, required 1 %h", i, win_valid, dut_win(), mk(0));
      end
    end
    send(13, 1'b0, 0, 0, 12);
    drain();
    n_tests++;
    if (got_q.size() != 9 || got_q[1].px !== mk(1)) begin
      n_fail++;
      $display("FAIL bp_second: got %0d windows, required 9 with second %h", got_q.size(), mk(1));
    end
  endtask

  task automatic test_gapped();
    int bases[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    do_reset();
    clear_obs();
    send(0, 1'b0, 1, 0, W*H);
    drain();
    n_tests++;
    if (got_q.size() != 9) begin
      n_fail++;
      $display("FAIL gap_count: got %0d windows, required 9", got_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (got_q[i].px !== mk(bases[i])) begin
          n_fail++;
          $display("FAIL gap_order: window %0d got %h, required %h", i, got_q[i].px, mk(bases[i]));
        end
      end
    end
    n_tests++;
    if (saw_45) begin
      n_fail++;
      $display("FAIL gap_row_edge: got a window with 4,5 neighbours, required none");
    end
  endtask

  task automatic test_mid_reset();
    bit clean = 1'b1;
    do_reset();
    send(0, 1'b0, 0, 0, 8);
    do_reset();
    clear_obs();
    send(100, 1'b0, 0, 0, W*H);
    drain();
    foreach (got_q[i])
      for (int k = 0; k < 9; k++)
        if (got_q[i].px[k] < P'(100)) clean = 1'b0;
    n_tests++;
    if (got_q.size() != 9 || got_q[0].px !== mk(100) || !clean) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d windows clean=%b, required 9 clean=1 first %h",
               got_q.size(), clean, mk(100));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_obs();
    send(0, 1'b0, 0, 0, W*H);
    send(200, 1'b0, 0, 0, W*H);
    drain();
    n_tests++;
    if (got_q.size() != 18 || last_count != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d windows %0d lasts, required 18 2", got_q.size(), last_count);
    end else begin
      n_tests++;
      if (got_q[9].px !== mk(200) || got_q[8].last !== 1'b1 || got_q[17].last !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_second_frame: got %h, required %h with last on 8 and 17",
                 got_q[9].px, mk(200));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    clear_obs();
    send(0, 1'b1, 2, 1, 3*W*H);
    drain();
    n_tests++;
    if (got_q.size() != 27 || last_count != 3) begin
      n_fail++;
      $display("FAIL random_count: got %0d windows %0d lasts, required 27 3", got_q.size(), last_count);
    end
  endtask

  initial begin
    reset     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_gapped();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Upstream neighbour of the line_buffer/convolution stage in the basecnn datapath.
- Takes a raster-order 8-bit pixel stream, one pixel per accepted beat, and stores the two previous rows in row memories.
- Emits each complete 3x3 window ("valid" convolution, no padding) on nine 8-bit outputs that map directly onto image0..image8.
- Uses a valid/ready handshake on both sides, so a busy convolution stage back-pressures the pixel source.

Parameters:
- IMG_W, 28: pixels per row; must be at least 3.
- IMG_H, 28: rows per frame; must be at least 3.
- PIX_W, 8: pixel width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; 0 = reset asserted.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- win0..win8  out  PIX_W each  3x3 window. win0 = (r-2,c-2), win1 = (r-2,c-1), win2 = (r-2,c), ..., win8 = (r,c), the newest pixel.
- win_valid  out  1  window outputs hold a valid window.
- win_ready  in  1  downstream consumes the window this cycle.
- win_last  out  1  qualifies win_valid; marks the final window of the frame.

Behaviour:
- Reset (reset==0 at a clk edge):
  - win_valid, win_last, win0..win8, col and row counters all go to 0; state goes to FILL.
  - Pixels presented while reset is low are dropped.
  - Row memories are not reset; their contents are never exposed until overwritten.
- pix_ready = !win_valid || win_ready. This is combinational and holds no skid buffer.
- Accept = pix_valid && pix_ready. With no accept, all state holds.
- On accept at column c:
  - Read top = rowB[c] and mid = rowA[c].
  - Write rowB[c] <= rowA[c] and rowA[c] <= pix_in.
  - Shift the window columns left (win0<=win1, win1<=win2, win3<=win4, and so on).
  - Load the new right column: win2 = top, win5 = mid, win8 = pix_in.
- Window valid:
  - On an accept with row >= 2 and col >= 2, win_valid is 1 on the next cycle. Latency is one cycle from accept to window.
  - Otherwise, if win_ready is 1, win_valid clears.
- While win_valid==1 && win_ready==0, win0..win8, win_valid and win_last must stay stable.
- Counters:
  - col increments per accept and wraps at IMG_W-1 to 0, incrementing row.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next accept starts a new frame.
- State machine:
  - FILL: rows 0..1. No windows are produced.
  - STREAM: rows 2..IMG_H-1.
  - STREAM returns to FILL on the frame wrap.
- Row edges:
  - Columns 0..1 of each row refill the window columns without producing output.
  - No window may mix pixels from two different rows' column ranges.
- win_last is set with the window produced by the accept at (IMG_H-1, IMG_W-1) and cleared with it.
- Frame output: exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Simultaneous win_ready and a new accept that produces a window: win_valid stays 1 and the window updates.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). No arithmetic is performed on pixel data.

Decomposition:
- Shared package cnn_pkg: PIX_W, default IMG_W/IMG_H, and a state enum {FILL, STREAM}.
- One sub-module: row_ram, an IMG_W x PIX_W memory with one combinational read and one synchronous write per cycle at the same address, returning old data. Instance it twice (rowA, rowB).

Test Plan:
- IMG_W=IMG_H=5, pixels 0..24, win_ready=1 throughout:
  - First win_valid comes one cycle after accepting pixel 12, with windows 0,1,2,5,6,7,10,11,12.
  - Exactly 9 windows are produced.
  - The last window is 12,13,14,17,18,19,22,23,24 with win_last=1.
- Back-pressure: hold win_ready=0 for 3 cycles at the first window.
  - pix_ready=0 for those cycles.
  - Window 0,1,2,5,6,7,10,11,12 stays stable.
  - No pixel is lost; the second window is 1,2,3,6,7,8,11,12,13.
- Gapped input: pix_valid toggles 1/0 each cycle.
  - Same 9 windows in the same order.
  - win_valid is never asserted for two windows from a single accept.
- Row edge check: no window contains both 4 and 5 as horizontal neighbours. For example, window 3,4,5,... never appears.
- Mid-frame reset: drive reset=0 after pixel 7, then stream 100..124.
  - First window is 100,101,102,105,106,107,110,111,112.
  - Nothing from the aborted frame appears.
- Back-to-back frames 0..24 then 200..224:
  - The second frame's first window is 200,201,202,205,206,207,210,211,212.
  - win_last pulses once per frame.
